// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory port of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters and the memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_addr, mem_read, mem_write, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_addr, mem_read, mem_write, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction fetch and data.
// One access at a time: IDLE samples requests, ACCESS holds the strobe, RESP pulses the owner's ack.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, last_grant_q, grant;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        any_req;
  logic        last_cycle;

  // Next-state, grant selection and outputs.
  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    any_req    = bus.if_req | bus.d_req;
    last_cycle = (cnt_q == 4'd0);

    // Contended grant goes to whichever port did not win last time.
    grant = OWN_FETCH;
    if (bus.if_req && bus.d_req) begin
      grant = (last_grant_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (bus.d_req) begin
      grant = OWN_DATA;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)    state_d = ACCESS;
      ACCESS:  if (last_cycle) state_d = RESP;
      RESP:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.if_ack    = 1'b0;
    bus.d_ack     = 1'b0;
    if (state_q == ACCESS) begin
      bus.mem_read  = ~we_q;
      bus.mem_write = we_q;
    end
    if (state_q == RESP) begin
      bus.if_ack = (owner_q == OWN_FETCH);
      bus.d_ack  = (owner_q == OWN_DATA);
    end

    bus.busy      = (state_q != IDLE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the read-data registers are reset too, because their value is visible on the ports.
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_DATA;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            cnt_q        <= LAT_LOAD;
            if (grant == OWN_DATA) begin
              we_q    <= bus.d_we;
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
            end else begin
              // Fetches never write; the write-data bus keeps its last value.
              we_q   <= 1'b0;
              addr_q <= bus.if_addr;
            end
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!we_q) begin
              if (owner_q == OWN_FETCH) if_rdata_q <= bus.mem_rdata;
              else                      d_rdata_q  <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, number of cycles the memory strobe is held per access (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_rdata  output  32  fetch read data, valid while if_ack=1.
REQ-007 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-009 SHALL have port d_we  input  1  data write enable (1 = store, 0 = load).
REQ-010 SHALL have port d_addr  input  32  data address.
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_rdata  output  32  load data, valid while d_ack=1.
REQ-013 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port mem_addr  output  32  shared memory address.
REQ-015 SHALL have port mem_read  output  1  shared memory read strobe.
REQ-016 SHALL have port mem_write  output  1  shared memory write strobe.
REQ-017 SHALL have port mem_wdata  output  32  shared memory write data.
REQ-018 SHALL have port mem_rdata  input  32  shared memory read data, valid in the last strobe cycle.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-021 In IDLE with no request: SHALL stay in IDLE with all strobes and acks low.
REQ-022 In IDLE with any request: SHALL select an owner, register the owner's addr/we/wdata, load the latency counter with MEM_LATENCY-1, and move to ACCESS at the next edge.
REQ-023 Selection SHALL be: a single requester wins outright; when both request, the one not granted last wins (round-robin). A last_grant flag SHALL update on every grant.
REQ-024 In ACCESS: mem_addr/mem_wdata SHALL drive the registered values; mem_read = !we, mem_write = we; both SHALL be held stable for exactly MEM_LATENCY cycles.
REQ-025 The counter SHALL decrement each ACCESS cycle. At count 0 the block SHALL capture mem_rdata (loads only) into the owner's rdata register and move to RESP.
REQ-026 In RESP: SHALL assert exactly the owner's ack for one cycle, with strobes low, then return to IDLE.
REQ-027 Request-to-ack latency SHALL be MEM_LATENCY+1 cycles after the IDLE sampling edge. Minimum issue-to-issue spacing SHALL be MEM_LATENCY+2 cycles.
REQ-028 Each requester SHALL drop its req, or present a new request, in the cycle after its ack. A req high while in IDLE SHALL be treated as a new request.
REQ-029 if_rdata/d_rdata SHALL hold their last captured value until the next load completes for that port. A store SHALL NOT alter d_rdata.
REQ-030 Request-input changes during ACCESS/RESP SHALL NOT affect the access in flight. A non-owner request stays pending and SHALL be served next.
REQ-031 Outside ACCESS, mem_addr/mem_wdata SHALL hold their last value, and mem_read and mem_write SHALL be 0.
REQ-032 mem_read and mem_write SHALL never both be 1. if_ack and d_ack SHALL never both be 1.

Reset
REQ-033 While rst=1 at an edge: state=IDLE, counter=0, last_grant=data (so the first contended grant goes to fetch), all acks/strobes/busy=0, if_rdata=d_rdata=mem_addr=mem_wdata=0.
REQ-034 Reset during ACCESS or RESP SHALL abort the access with no ack issued. Strobes SHALL be low in the cycle after the reset edge.

Verification (MEM_LATENCY=2)
REQ-035 Single fetch: if_req=1, if_addr=0x10 in IDLE at cycle 0 -> mem_read=1, mem_addr=0x10 in cycles 1-2; mem_rdata=0xDEADBEEF in cycle 2 -> if_ack=1, if_rdata=0xDEADBEEF in cycle 3; busy=0 in cycle 4.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> mem_write=1, mem_wdata=0x1234 for 2 cycles, mem_read=0 throughout; d_ack=1 in cycle 3; d_rdata unchanged.
REQ-037 Contention after reset: both req high at cycle 0 -> fetch served first (if_ack cycle 3); data access starts in cycle 5 with d_ack in cycle 7.
REQ-038 Sustained contention: both req reasserted immediately after each ack for 6 transactions -> grants strictly alternate; neither port waits more than 2 transactions.
REQ-039 Reset mid-access: rst=1 in cycle 1 of a load -> no ack ever pulses; mem_read=0 and busy=0 from cycle 2; rdata registers=0.
REQ-040 Latency sweep: MEM_LATENCY=1 and MEM_LATENCY=15 -> strobe width equals MEM_LATENCY, ack arrives MEM_LATENCY+1 cycles after the IDLE sampling edge.
